// File: rtl/tom_int_pkg.sv
// Shared definitions for the Tom interrupt sequencer: FSM states, widths,
// source indices and the priority-pick helper.
package tom_int_pkg;

    localparam int NSRC_DEF = 5;
    localparam int VEC_W    = 3;

    localparam logic [VEC_W-1:0] VID = 3'd0;
    localparam logic [VEC_W-1:0] GPU = 3'd1;
    localparam logic [VEC_W-1:0] OBJ = 3'd2;
    localparam logic [VEC_W-1:0] TIM = 3'd3;
    localparam logic [VEC_W-1:0] JER = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Index 0 is the highest priority, so the lowest set bit wins.
    function automatic logic [VEC_W-1:0] lowest_idx(input logic [7:0] req);
        logic [VEC_W-1:0] idx;
        idx = {VEC_W{1'b0}};
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) idx = VEC_W'(i);
            else        idx = idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/tom_intlatch.sv
// One pending bit with set-over-clear priority.
// TOM_INTCTL_EDGE_EN selects rising-edge detection; otherwise the source is level sensitive.
module tom_intlatch
    import tom_int_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic src,
    input  logic clr,
    output logic pend
);

    logic pend_r;
    logic event_s;

`ifdef TOM_INTCTL_EDGE_EN
    logic src_q_r;

    // Source history for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) src_q_r <= 1'b0;
        else       src_q_r <= src;
    end

    assign event_s = src & ~src_q_r;
`else
    assign event_s = src;
`endif

    // Pending bit: a new event beats any clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        pend_r <= 1'b0;
        else if (event_s) pend_r <= 1'b1;
        else if (clr)     pend_r <= 1'b0;
        else              pend_r <= pend_r;
    end

    assign pend = pend_r;

endmodule

// File: rtl/tom_intctl.sv
// Tom interrupt sequencer top: mask register, priority pick and irq/ack FSM.
// Optional macro TOM_INTCTL_EDGE_EN makes source inputs edge sensitive.
module tom_intctl
    import tom_int_pkg::*;
#(
    parameter int NSRC = NSRC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NSRC-1:0]  src,
    input  logic             mask_wr,
    input  logic [NSRC-1:0]  mask_d,
    input  logic             clr_wr,
    input  logic [NSRC-1:0]  clr_d,
    input  logic             ack,
    output logic             irq,
    output logic [VEC_W-1:0] vec,
    output logic [NSRC-1:0]  pend,
    output logic [NSRC-1:0]  mask
);

    state_t            state_r, state_nx;
    logic [VEC_W-1:0]  vec_r, vec_nx;
    logic              irq_r, irq_nx;
    logic [NSRC-1:0]   mask_r;
    logic [NSRC-1:0]   pend_s;
    logic [NSRC-1:0]   clr_s;
    logic [7:0]        req_ext_s;
    logic              ack_clr_s;

    assign ack_clr_s = (state_r == REQ) & ack;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        assign clr_s[g] = (clr_wr & clr_d[g]) | (ack_clr_s & (vec_r == VEC_W'(g)));

        tom_intlatch u_latch (
            .clk   (clk),
            .reset (reset),
            .src   (src[g]),
            .clr   (clr_s[g]),
            .pend  (pend_s[g])
        );
    end

    // Enabled requests widened to the priority helper's fixed width.
    always_comb begin
        req_ext_s             = 8'h00;
        req_ext_s[NSRC-1:0]   = pend_s & mask_r;
    end

    // Next-state logic; vec only moves when a new request is launched.
    always_comb begin
        state_nx = state_r;
        vec_nx   = vec_r;
        case (state_r)
            IDLE: begin
                if (|req_ext_s) begin
                    state_nx = REQ;
                    vec_nx   = lowest_idx(req_ext_s);
                end else begin
                    state_nx = IDLE;
                end
            end
            REQ: begin
                if (ack) state_nx = WAIT;
                else     state_nx = REQ;
            end
            WAIT: begin
                if (!ack) state_nx = IDLE;
                else      state_nx = WAIT;
            end
            default: state_nx = IDLE;
        endcase
        irq_nx = (state_nx == REQ);
    end

    // FSM and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            vec_r   <= {VEC_W{1'b0}};
            irq_r   <= 1'b0;
        end else begin
            state_r <= state_nx;
            vec_r   <= vec_nx;
            irq_r   <= irq_nx;
        end
    end

    // Enable mask; writes never touch the pending bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        mask_r <= {NSRC{1'b0}};
        else if (mask_wr) mask_r <= mask_d;
        else              mask_r <= mask_r;
    end

    assign irq  = irq_r;
    assign vec  = vec_r;
    assign pend = pend_s;
    assign mask = mask_r;

endmodule

// File: tb/tb_tom_intctl.sv
// Bench for tom_intctl: rule-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_tom_intctl;

    localparam int NSRC = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NSRC-1:0] src = '0;
    logic            mask_wr = 1'b0;
    logic [NSRC-1:0] mask_d = '0;
    logic            clr_wr = 1'b0;
    logic [NSRC-1:0] clr_d = '0;
    logic            ack = 1'b0;
    logic            irq;
    logic [2:0]      vec;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;

    int checks = 0;
    int failures = 0;

    tom_intctl #(.NSRC(NSRC)) dut (
        .clk     (clk),
        .reset   (reset),
        .src     (src),
        .mask_wr (mask_wr),
        .mask_d  (mask_d),
        .clr_wr  (clr_wr),
        .clr_d   (clr_d),
        .ack     (ack),
        .irq     (irq),
        .vec     (vec),
        .pend    (pend),
        .mask    (mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bits as arrays, handshake as a phase number
    // (0 = waiting for work, 1 = requesting, 2 = waiting for ack release).
    bit m_pend[NSRC];
    bit m_mask[NSRC];
    bit m_prev[NSRC];
    bit m_np[NSRC];
    int m_phase = 0;
    int m_vec = 0;

`ifdef TOM_INTCTL_EDGE_EN
    localparam bit EDGE_MODE = 1'b1;
`else
    localparam bit EDGE_MODE = 1'b0;
`endif

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSRC; i++) begin
                m_pend[i] = 1'b0;
                m_mask[i] = 1'b0;
                m_prev[i] = 1'b0;
            end
            m_phase = 0;
            m_vec   = 0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                bit ev, cl;
                ev = src[i] && (!EDGE_MODE || !m_prev[i]);
                cl = (clr_wr && clr_d[i]) || (m_phase == 1 && ack && m_vec == i);
                m_np[i] = ev ? 1'b1 : (cl ? 1'b0 : m_pend[i]);
            end
            if (m_phase == 0) begin
                for (int i = NSRC - 1; i >= 0; i--)
                    if (m_pend[i] && m_mask[i]) begin
                        m_vec   = i;
                        m_phase = 1;
                    end
            end else if (m_phase == 1) begin
                if (ack) m_phase = 2;
            end else begin
                if (!ack) m_phase = 0;
            end
            for (int i = 0; i < NSRC; i++) begin
                m_pend[i] = m_np[i];
                m_prev[i] = src[i];
                if (mask_wr) m_mask[i] = mask_d[i];
            end
        end
    end

    // Every-cycle compare on the falling edge.
    always @(negedge clk) begin
        logic [7:0] ep, em;
        ep = 8'h00;
        em = 8'h00;
        for (int i = 0; i < NSRC; i++) begin
            ep[i] = m_pend[i];
            em[i] = m_mask[i];
        end
        check("model_irq",  {7'd0, irq}, {7'd0, (m_phase == 1)});
        check("model_vec",  {5'd0, vec}, 8'(m_vec));
        check("model_pend", {3'd0, pend}, ep);
        check("model_mask", {3'd0, mask}, em);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_mask(input logic [NSRC-1:0] m);
        mask_wr = 1'b1;
        mask_d  = m;
        tick(1);
        mask_wr = 1'b0;
    endtask

    task automatic handshake();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(2);
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        check("rst_irq",  {7'd0, irq}, 8'h00);
        check("rst_vec",  {5'd0, vec}, 8'h00);
        check("rst_pend", {3'd0, pend}, 8'h00);
        check("rst_mask", {3'd0, mask}, 8'h00);

        // Single source
        set_mask(5'b00100);
        src = 5'b00100;
        tick(1);
        src = 5'b00000;
        check("single_pend", {3'd0, pend}, 8'h04);
        check("single_irq_early", {7'd0, irq}, 8'h00);
        tick(1);
        check("single_irq", {7'd0, irq}, 8'h01);
        check("single_vec", {5'd0, vec}, 8'h02);
        ack = 1'b1;
        tick(1);
        check("single_ack_irq",  {7'd0, irq}, 8'h00);
        check("single_ack_pend", {3'd0, pend}, 8'h00);
        tick(1);
        ack = 1'b0;
        tick(2);
        check("single_idle_irq", {7'd0, irq}, 8'h00);

        // Priority between two simultaneous sources
        set_mask(5'b11111);
        src = 5'b10010;
        tick(1);
        src = 5'b00000;
        tick(1);
        check("prio_vec1", {5'd0, vec}, 8'h01);
        ack = 1'b1;
        tick(1);
        check("prio_pend_left", {3'd0, pend}, 8'h10);
        ack = 1'b0;
        tick(1);
        check("prio_gap_irq", {7'd0, irq}, 8'h00);
        tick(1);
        check("prio_irq2", {7'd0, irq}, 8'h01);
        check("prio_vec2", {5'd0, vec}, 8'h04);
        handshake();

        // Masked pending, then unmasked
        set_mask(5'b00000);
        src = 5'b01000;
        tick(1);
        src = 5'b00000;
        tick(2);
        check("masked_pend", {3'd0, pend}, 8'h08);
        check("masked_irq",  {7'd0, irq}, 8'h00);
        set_mask(5'b01000);
        check("unmask_irq_early", {7'd0, irq}, 8'h00);
        tick(1);
        check("unmask_irq", {7'd0, irq}, 8'h01);
        check("unmask_vec", {5'd0, vec}, 8'h03);
        handshake();

        // Set beats clear
        set_mask(5'b00000);
        clr_wr = 1'b1;
        clr_d  = 5'b00001;
        src    = 5'b00001;
        tick(1);
        src = 5'b00000;
        check("set_wins_pend", {3'd0, pend}, 8'h01);
        tick(1);
        clr_wr = 1'b0;
        clr_d  = 5'b00000;
        check("clear_pend", {3'd0, pend}, 8'h00);

        // Clear during REQ does not withdraw the request
        set_mask(5'b00010);
        src = 5'b00010;
        tick(1);
        src = 5'b00000;
        tick(1);
        clr_wr = 1'b1;
        clr_d  = 5'b00010;
        tick(1);
        clr_wr = 1'b0;
        check("clr_req_pend", {3'd0, pend}, 8'h00);
        check("clr_req_irq",  {7'd0, irq}, 8'h01);
        handshake();

        // Held source: edge vs level
        set_mask(5'b00001);
        src = 5'b00001;
        tick(2);
        check("held_irq1", {7'd0, irq}, 8'h01);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(2);
        check("held_irq2", {7'd0, irq}, EDGE_MODE ? 8'h00 : 8'h01);
        tick(5);
        src = 5'b00000;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(2);
        check("held_end_pend", {3'd0, pend}, 8'h00);
        check("held_end_irq",  {7'd0, irq}, 8'h00);

        // Reset mid-REQ
        set_mask(5'b00100);
        src = 5'b00100;
        tick(1);
        src = 5'b00000;
        tick(1);
        check("mid_irq", {7'd0, irq}, 8'h01);
        check("mid_vec", {5'd0, vec}, 8'h02);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_irq",  {7'd0, irq}, 8'h00);
        check("mid_rst_pend", {3'd0, pend}, 8'h00);
        check("mid_rst_mask", {3'd0, mask}, 8'h00);
        check("mid_rst_vec",  {5'd0, vec}, 8'h00);
        reset = 1'b0;
        ack = 1'b1;
        tick(2);
        ack = 1'b0;
        tick(1);
        check("post_rst_irq",  {7'd0, irq}, 8'h00);
        check("post_rst_pend", {3'd0, pend}, 8'h00);

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
